// File: rtl/transport_down_arbiter.sv
// Packet-granular round-robin arbiter sharing the PAICore downstream send port between
// a config stream (src0) and a work stream (src1). Optional packet counters: `FRAME_CNT_EN.
module transport_down_arbiter #(
    parameter int DATA_W        = 64,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic              i_en,
    input  logic              i_clr_err,
    input  logic              s0_axis_tvalid,
    input  logic [DATA_W-1:0] s0_axis_tdata,
    input  logic              s0_axis_tlast,
    output logic              s0_axis_tready,
    input  logic              s1_axis_tvalid,
    input  logic [DATA_W-1:0] s1_axis_tdata,
    input  logic              s1_axis_tlast,
    output logic              s1_axis_tready,
    input  logic              i_send_available,
    output logic              o_send_valid,
    output logic [DATA_W-1:0] o_send_pdata,
    output logic [1:0]        o_grant,
    output logic              o_busy,
    output logic              o_tx_done,
    output logic              o_stall_err
`ifdef FRAME_CNT_EN
    ,
    output logic [CNT_W-1:0]  o_s0_pkt_cnt,
    output logic [CNT_W-1:0]  o_s1_pkt_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_served_q, last_served_d;   // 1: src1 was served most recently

    logic        lock;
    logic        sel_valid;
    logic        sel_last;
    logic [DATA_W-1:0] sel_data;
    logic        hs;
    logic        done;

    always_comb begin
        lock      = (state_q == LOCK);
        sel_valid = grant_q[1] ? s1_axis_tvalid : s0_axis_tvalid;
        sel_last  = grant_q[1] ? s1_axis_tlast  : s0_axis_tlast;
        sel_data  = grant_q[1] ? s1_axis_tdata  : s0_axis_tdata;
        hs        = lock && sel_valid && i_send_available;
        done      = hs && sel_last;
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_served_d = last_served_q;
        if (state_q == IDLE) begin
            if (i_en && (s0_axis_tvalid || s1_axis_tvalid)) begin
                state_d = LOCK;
                if (s0_axis_tvalid && s1_axis_tvalid)
                    grant_d = last_served_q ? 2'b01 : 2'b10;
                else
                    grant_d = s0_axis_tvalid ? 2'b01 : 2'b10;
            end
        end else begin
            if (done) begin
                state_d       = IDLE;
                grant_d       = 2'b00;
                last_served_d = grant_q[1];
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q       <= IDLE;
            grant_q       <= 2'b00;
            last_served_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_served_q <= last_served_d;
        end
    end

    // Zero-latency data path; pdata forced to 0 outside LOCK so nothing leaks downstream.
    assign o_send_valid   = lock && sel_valid;
    assign o_send_pdata   = lock ? sel_data : '0;
    assign s0_axis_tready = lock && grant_q[0] && i_send_available;
    assign s1_axis_tready = lock && grant_q[1] && i_send_available;
    assign o_grant        = grant_q;
    assign o_busy         = lock;
    assign o_tx_done      = done;

    generate
        if (STALL_TIMEOUT > 0) begin : g_watchdog
            localparam int SW = $clog2(STALL_TIMEOUT + 1);
            localparam logic [SW-1:0] STALL_MAX = SW'(STALL_TIMEOUT);

            logic [SW-1:0] stall_q, stall_d;
            logic          err_q, err_d;

            always_comb begin
                stall_d = '0;
                if (lock && !hs)
                    stall_d = (stall_q == STALL_MAX) ? stall_q : stall_q + 1'b1;
                err_d = err_q;
                if (i_clr_err)
                    err_d = 1'b0;
                if (stall_d == STALL_MAX)
                    err_d = 1'b1;
            end

            always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
                if (!s_axis_aresetn) begin
                    stall_q <= '0;
                    err_q   <= 1'b0;
                end else begin
                    stall_q <= stall_d;
                    err_q   <= err_d;
                end
            end

            assign o_stall_err = err_q;
        end else begin : g_no_watchdog
            assign o_stall_err = 1'b0;
        end
    endgenerate

`ifdef FRAME_CNT_EN
    logic [CNT_W-1:0] s0_cnt_q, s0_cnt_d;
    logic [CNT_W-1:0] s1_cnt_q, s1_cnt_d;

    always_comb begin
        s0_cnt_d = s0_cnt_q;
        s1_cnt_d = s1_cnt_q;
        if (done && grant_q[0]) s0_cnt_d = s0_cnt_q + 1'b1;
        if (done && grant_q[1]) s1_cnt_d = s1_cnt_q + 1'b1;
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            s0_cnt_q <= '0;
            s1_cnt_q <= '0;
        end else begin
            s0_cnt_q <= s0_cnt_d;
            s1_cnt_q <= s1_cnt_d;
        end
    end

    assign o_s0_pkt_cnt = s0_cnt_q;
    assign o_s1_pkt_cnt = s1_cnt_q;
`endif

endmodule

// File: tb/tb_transport_down_arbiter.sv
// Scoreboard bench for transport_down_arbiter: directed packets push expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_transport_down_arbiter;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              i_en = 1'b1;
    logic              i_clr_err = 1'b0;
    logic              s0_axis_tvalid = 1'b0;
    logic [DATA_W-1:0] s0_axis_tdata = '0;
    logic              s0_axis_tlast = 1'b0;
    logic              s0_axis_tready;
    logic              s1_axis_tvalid = 1'b0;
    logic [DATA_W-1:0] s1_axis_tdata = '0;
    logic              s1_axis_tlast = 1'b0;
    logic              s1_axis_tready;
    logic              i_send_available = 1'b1;
    logic              o_send_valid;
    logic [DATA_W-1:0] o_send_pdata;
    logic [1:0]        o_grant;
    logic              o_busy;
    logic              o_tx_done;
    logic              o_stall_err;
`ifdef FRAME_CNT_EN
    logic [CNT_W-1:0]  o_s0_pkt_cnt;
    logic [CNT_W-1:0]  o_s1_pkt_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic done3 = 1'b0;

    typedef struct packed {
        logic [1:0]        grant;
        logic [DATA_W-1:0] data;
        logic              last;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    transport_down_arbiter #(
        .DATA_W(DATA_W), .STALL_TIMEOUT(8), .CNT_W(CNT_W)
    ) dut (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .i_en(i_en), .i_clr_err(i_clr_err),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tdata(s0_axis_tdata),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tdata(s1_axis_tdata),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
        .i_send_available(i_send_available), .o_send_valid(o_send_valid),
        .o_send_pdata(o_send_pdata), .o_grant(o_grant), .o_busy(o_busy),
        .o_tx_done(o_tx_done), .o_stall_err(o_stall_err)
`ifdef FRAME_CNT_EN
        , .o_s0_pkt_cnt(o_s0_pkt_cnt), .o_s1_pkt_cnt(o_s1_pkt_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic push_pkt(input int src, input int n, input logic [63:0] base);
        for (int b = 0; b < n; b++)
            exp_q.push_back('{grant: (src == 0) ? 2'b01 : 2'b10,
                              data: base + 64'(b), last: (b == n - 1)});
    endtask

    task automatic drive_beat(input int src, input logic [63:0] d, input logic last);
        logic h;
        int   budget;
        if (src == 0) begin
            s0_axis_tvalid = 1'b1; s0_axis_tdata = d; s0_axis_tlast = last;
        end else begin
            s1_axis_tvalid = 1'b1; s1_axis_tdata = d; s1_axis_tlast = last;
        end
        budget = 0;
        h = 1'b0;
        while (!h) begin
            @(negedge clk);
            h = (src == 0) ? s0_axis_tready : s1_axis_tready;
            @(posedge clk);
            #1;
            budget++;
            if (!h && budget > 300) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout src=%0d actual=no_ready required=ready", src);
                h = 1'b1;
            end
        end
    endtask

    task automatic send_pkt(input int src, input int n, input logic [63:0] base);
        for (int b = 0; b < n; b++)
            drive_beat(src, base + 64'(b), (b == n - 1));
    endtask

    task automatic idle_src(input int src);
        if (src == 0) begin
            s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
        end else begin
            s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
        end
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_send_valid && i_send_available) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", o_send_pdata, '0);
                    check("unexpected_beat_seen", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    $display("beat grant=%b data=%h tx_done=%b", o_grant, o_send_pdata, o_tx_done);
                    check("beat_grant", 64'(o_grant), 64'(e.grant));
                    check("beat_data", o_send_pdata, e.data);
                    check("beat_tx_done", 64'(o_tx_done), 64'(e.last));
                end
            end else begin
                check("tx_done_no_hs", 64'(o_tx_done), 64'd0);
            end
            if (!o_busy)
                check("pdata_idle_zero", o_send_pdata, 64'd0);
            else begin
                check("s0_tready", 64'(s0_axis_tready), 64'(o_grant[0] & i_send_available));
                check("s1_tready", 64'(s1_axis_tready), 64'(o_grant[1] & i_send_available));
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_grant", 64'(o_grant), 64'd0);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_stall_err", 64'(o_stall_err), 64'd0);
        check("rst_send_valid", 64'(o_send_valid), 64'd0);
        check("rst_treadys", 64'({s0_axis_tready, s1_axis_tready}), 64'd0);
`ifdef FRAME_CNT_EN
        check("rst_cnts", 64'({o_s0_pkt_cnt, o_s1_pkt_cnt}), 64'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: src0 alone, 3 beats; grant visible one cycle after request
        push_pkt(0, 3, 64'hA000_0000_0000_0100);
        fork
            send_pkt(0, 3, 64'hA000_0000_0000_0100);
            begin
                @(negedge clk);
                check("t1_grant_before_edge", 64'(o_grant), 64'd0);
                check("t1_no_send_in_idle", 64'(o_send_valid), 64'd0);
                @(negedge clk);
                check("t1_grant", 64'(o_grant), 64'd1);
            end
        join
        idle_src(0);
        @(negedge clk);
        check("t1_idle_grant", 64'(o_grant), 64'd0);
        check("t1_idle_busy", 64'(o_busy), 64'd0);

        // 2: both continuously valid; src0 served last, so src1 wins first
        push_pkt(1, 2, 64'hB000_0000_0000_0100);
        push_pkt(0, 2, 64'hA000_0000_0000_0200);
        push_pkt(1, 2, 64'hB000_0000_0000_0200);
        push_pkt(0, 2, 64'hA000_0000_0000_0300);
        @(posedge clk); #1;
        fork
            begin
                send_pkt(0, 2, 64'hA000_0000_0000_0200);
                send_pkt(0, 2, 64'hA000_0000_0000_0300);
                idle_src(0);
            end
            begin
                send_pkt(1, 2, 64'hB000_0000_0000_0100);
                send_pkt(1, 2, 64'hB000_0000_0000_0200);
                idle_src(1);
            end
        join

        // 3: availability toggling mid-packet
        push_pkt(0, 3, 64'hA000_0000_0000_0400);
        @(posedge clk); #1;
        done3 = 1'b0;
        fork
            begin
                send_pkt(0, 3, 64'hA000_0000_0000_0400);
                idle_src(0);
                done3 = 1'b1;
            end
            begin
                while (!done3) begin
                    @(posedge clk); #1;
                    i_send_available = ~i_send_available;
                end
                i_send_available = 1'b1;
            end
        join

        // 4: src1 stalls 10 cycles after first beat; error after 8 idle cycles
        @(posedge clk); #1;
        push_pkt(1, 3, 64'hC000_0000_0000_0100);
        drive_beat(1, 64'hC000_0000_0000_0100, 1'b0);
        s1_axis_tvalid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t4_stall_err_k%0d", k), 64'(o_stall_err), 64'(k >= 8));
            check("t4_grant_held", 64'(o_grant), 64'd2);
        end
        drive_beat(1, 64'hC000_0000_0000_0101, 1'b0);
        drive_beat(1, 64'hC000_0000_0000_0102, 1'b1);
        idle_src(1);
        @(negedge clk);
        check("t4_err_sticky", 64'(o_stall_err), 64'd1);
        @(posedge clk); #1 i_clr_err = 1'b1;
        @(posedge clk); #1 i_clr_err = 1'b0;
        @(negedge clk);
        check("t4_err_cleared", 64'(o_stall_err), 64'd0);

        // 5: i_en drops during src0 packet with src1 pending
        @(posedge clk); #1;
        push_pkt(0, 3, 64'hA000_0000_0000_0500);
        push_pkt(1, 2, 64'hD000_0000_0000_0100);
        s1_axis_tvalid = 1'b1; s1_axis_tdata = 64'hD000_0000_0000_0100; s1_axis_tlast = 1'b0;
        fork
            send_pkt(0, 3, 64'hA000_0000_0000_0500);
            begin
                repeat (2) @(posedge clk);
                #1 i_en = 1'b0;
            end
        join
        idle_src(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_grant_disabled", 64'(o_grant), 64'd0);
            check("t5_s1_not_ready", 64'(s1_axis_tready), 64'd0);
        end
        i_en = 1'b1;
        send_pkt(1, 2, 64'hD000_0000_0000_0100);
        idle_src(1);
        @(negedge clk);
`ifdef FRAME_CNT_EN
        check("t6_s0_cnt_wrap", 64'(o_s0_pkt_cnt), 64'd1);
        check("t6_s1_cnt_wrap", 64'(o_s1_pkt_cnt), 64'd0);
`endif

        // 6: reset mid-packet; remaining beats form a new packet afterward
        @(posedge clk); #1;
        push_pkt(0, 1, 64'hE000_0000_0000_0000);
        exp_q[exp_q.size() - 1].last = 1'b0;
        drive_beat(0, 64'hE000_0000_0000_0000, 1'b0);
        s0_axis_tdata = 64'hE000_0000_0000_0001;
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_grant", 64'(o_grant), 64'd0);
        check("t6_rst_busy", 64'(o_busy), 64'd0);
        check("t6_rst_send_valid", 64'(o_send_valid), 64'd0);
        check("t6_rst_s0_ready", 64'(s0_axis_tready), 64'd0);
`ifdef FRAME_CNT_EN
        check("t6_rst_cnts", 64'({o_s0_pkt_cnt, o_s1_pkt_cnt}), 64'd0);
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        exp_q.push_back('{grant: 2'b01, data: 64'hE000_0000_0000_0001, last: 1'b0});
        exp_q.push_back('{grant: 2'b01, data: 64'hE000_0000_0000_0002, last: 1'b1});
        drive_beat(0, 64'hE000_0000_0000_0001, 1'b0);
        drive_beat(0, 64'hE000_0000_0000_0002, 1'b1);
        idle_src(0);

        for (int k = 0; k < 50 && exp_q.size() != 0; k++)
            @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
